sprite_motion: RTL and testbench

//  Upstream of the VGA color/timing stage. Computes the square sprite's top-left

---
 rtl/vga_pkg.sv | 58 +++++
 rtl/edge_rise.sv | 28 ++
 rtl/sprite_motion.sv | 126 ++++++++++++
 tb/tb_sprite_motion.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 800x600 timing constants, sprite FSM states and the per-axis
// bounce step used by sprite_motion.
package vga_pkg;

    localparam int unsigned HD    = 800;
    localparam int unsigned VD    = 600;
    localparam int unsigned HR    = 120;
    localparam int unsigned VR    = 6;
    localparam int unsigned H_END = 1040;
    localparam int unsigned V_END = 666;
    localparam int unsigned POS_W = 10;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [POS_W:0]   span_t;

    typedef enum logic [1:0] {
        S_WAIT,
        S_HOLD,
        S_UPDATE
    } state_t;

    typedef struct packed {
        pos_t pos;
        logic dir;
        logic hit;
    } axis_t;

    // One axis step with edge clamp; one extra bit so the sum never wraps.
    function automatic axis_t step_axis(input pos_t pos, input logic dir,
                                        input span_t step, input span_t lim);
        axis_t r;
        span_t nx;
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        if (dir) begin
            nx = {1'b0, pos} + step;
            if (nx >= lim) begin
                r.pos = lim[POS_W-1:0];
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = nx[POS_W-1:0];
            end
        end else begin
            nx = {1'b0, pos} - step;
            if ({1'b0, pos} <= step) begin
                r.pos = '0;
                r.dir = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.pos = nx[POS_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Single-bit rising-edge detector; the history flop resets to RESET_VAL.
module edge_rise #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite position update, bouncing off the 800x600 display edges.
// Optional button steering is enabled with `define SPRITE_STEER_EN.
module sprite_motion
    import vga_pkg::*;
#(
    parameter int unsigned SQ_W   = 20,
    parameter int unsigned SQ_H   = 20,
    parameter int unsigned SPEED  = 2,
    parameter int unsigned INIT_X = 390,
    parameter int unsigned INIT_Y = 290
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             pause,
    input  logic             btn_l,
    input  logic             btn_r,
    input  logic             btn_u,
    input  logic             btn_d,
    output logic [POS_W-1:0] sq_x,
    output logic [POS_W-1:0] sq_y,
    output logic             dir_x,
    output logic             dir_y,
    output logic [7:0]       bounce_cnt,
    output logic             frame_tick
);

    localparam span_t X_LIM = span_t'(HD - SQ_W);
    localparam span_t Y_LIM = span_t'(VD - SQ_H);
    localparam span_t STEP  = span_t'(SPEED);

    logic       tick;
    state_t     state_q, state_d;
    pos_t       sq_x_q, sq_x_d, sq_y_q, sq_y_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [7:0] bounce_cnt_q, bounce_cnt_d;
    logic       frame_tick_q, frame_tick_d;
    logic       dx, dy;
    axis_t      ax, ay;

    // History starts high so a vsync already asserted at reset release is not an edge.
    edge_rise #(.RESET_VAL(1'b1)) u_vsync_rise (
        .clk   (clk),
        .rst_n (reset),
        .d     (vsync),
        .rise  (tick)
    );

`ifndef SPRITE_STEER_EN
    logic unused_btn;
    assign unused_btn = ^{btn_l, btn_r, btn_u, btn_d};
`endif

    always_comb begin
        state_d      = state_q;
        sq_x_d       = sq_x_q;
        sq_y_d       = sq_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        bounce_cnt_d = bounce_cnt_q;
        frame_tick_d = tick;
        dx           = dir_x_q;
        dy           = dir_y_q;
        ax           = '0;
        ay           = '0;
        case (state_q)
            S_WAIT: begin
                if (pause) begin
                    state_d = S_HOLD;
                end else if (frame_tick_q) begin
                    state_d = S_UPDATE;
                end
            end
            S_HOLD: begin
                if (!pause) begin
                    state_d = S_WAIT;
                end
            end
            S_UPDATE: begin
                state_d = S_WAIT;
`ifdef SPRITE_STEER_EN
                if (btn_l != btn_r) dx = btn_r;
                if (btn_u != btn_d) dy = btn_d;
`endif
                ax      = step_axis(sq_x_q, dx, STEP, X_LIM);
                ay      = step_axis(sq_y_q, dy, STEP, Y_LIM);
                sq_x_d  = ax.pos;
                sq_y_d  = ay.pos;
                dir_x_d = ax.dir;
                dir_y_d = ay.dir;
                if (ax.hit || ay.hit) begin
                    bounce_cnt_d = bounce_cnt_q + 8'd1;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_WAIT;
            sq_x_q       <= pos_t'(INIT_X);
            sq_y_q       <= pos_t'(INIT_Y);
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            bounce_cnt_q <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sq_x_q       <= sq_x_d;
            sq_y_q       <= sq_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            bounce_cnt_q <= bounce_cnt_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sq_x       = sq_x_q;
    assign sq_y       = sq_y_q;
    assign dir_x      = dir_x_q;
    assign dir_y      = dir_y_q;
    assign bounce_cnt = bounce_cnt_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: a default instance plus one started near the
// bottom-right corner; steering expectations follow `SPRITE_STEER_EN.
module tb_sprite_motion;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vsync = 1'b0;
    logic       pause = 1'b0;
    logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;

    logic [9:0] sq_x, sq_y, c_x, c_y;
    logic       dir_x, dir_y, c_dx, c_dy;
    logic [7:0] bounce_cnt, c_bc;
    logic       frame_tick, c_ft;

    int total = 0;
    int bad   = 0;
    int n;

`ifdef SPRITE_STEER_EN
    localparam bit STEER = 1'b1;
`else
    localparam bit STEER = 1'b0;
`endif

    always #5 clk = ~clk;

    sprite_motion dut (
        .clk(clk), .reset(reset), .vsync(vsync), .pause(pause),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .sq_x(sq_x), .sq_y(sq_y), .dir_x(dir_x), .dir_y(dir_y),
        .bounce_cnt(bounce_cnt), .frame_tick(frame_tick)
    );

    sprite_motion #(.INIT_X(778), .INIT_Y(578)) dut_c (
        .clk(clk), .reset(reset), .vsync(vsync), .pause(pause),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .sq_x(c_x), .sq_y(c_y), .dir_x(c_dx), .dir_y(c_dy),
        .bounce_cnt(c_bc), .frame_tick(c_ft)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One short frame: vsync high 3 cycles, low 3 cycles; counts frame_tick pulses.
    task automatic frame(output int cnt);
        cnt = 0;
        @(negedge clk) vsync = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (frame_tick === 1'b1) cnt++;
        end
        vsync = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (frame_tick === 1'b1) cnt++;
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_x", sq_x, 390);
        chk("rst_y", sq_y, 290);
        chk("rst_dx", dir_x, 1);
        chk("rst_dy", dir_y, 1);
        chk("rst_bc", bounce_cnt, 0);
        chk("rst_ft", frame_tick, 0);
        chk("rst_cx", c_x, 778);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // first frame with latency: change lands on the 2nd edge after vsync sampled
        vsync = 1'b1;
        @(negedge clk);
        chk("lat_ft1", frame_tick, 1);
        chk("lat_x_n1", sq_x, 390);
        @(negedge clk);
        chk("lat_ft0", frame_tick, 0);
        chk("lat_x_n2", sq_x, 390);
        @(negedge clk);
        chk("f1_x", sq_x, 392);
        chk("f1_y", sq_y, 292);
        chk("f1_bc", bounce_cnt, 0);
        chk("corner_x", c_x, 780);
        chk("corner_y", c_y, 580);
        chk("corner_dx", c_dx, 0);
        chk("corner_dy", c_dy, 0);
        chk("corner_bc", c_bc, 1);
        vsync = 1'b0;
        repeat (3) @(negedge clk);

        frame(n);
        chk("f2_ticks", n, 1);
        chk("f2_x", sq_x, 394);
        chk("f2_y", sq_y, 294);
        chk("corner2_x", c_x, 778);
        chk("corner2_bc", c_bc, 1);

        // pause over three frames
        pause = 1'b1;
        for (int i = 0; i < 3; i++) frame(n);
        chk("pause_ticks", n, 1);
        chk("pause_x", sq_x, 394);
        chk("pause_y", sq_y, 294);
        pause = 1'b0;
        @(negedge clk);
        frame(n);
        chk("unpause_x", sq_x, 396);
        chk("unpause_y", sq_y, 296);
        chk("unpause_cx", c_x, 776);

        // pause asserted in the same cycle vsync rises
        @(negedge clk);
        pause = 1'b1;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        pause = 1'b0;
        @(negedge clk);
        chk("same_cyc_x", sq_x, 396);
        chk("same_cyc_y", sq_y, 296);

        // bottom edge exactly reached
        for (int i = 0; i < 142; i++) frame(n);
        chk("bot_y", sq_y, 580);
        chk("bot_dy", dir_y, 0);
        chk("bot_x", sq_x, 680);
        chk("bot_bc", bounce_cnt, 1);

        // right edge
        for (int i = 0; i < 50; i++) frame(n);
        chk("right_x", sq_x, 780);
        chk("right_dx", dir_x, 0);
        chk("right_y", sq_y, 480);
        chk("right_bc", bounce_cnt, 2);
        chk("c_mid_x", c_x, 392);
        chk("c_mid_y", c_y, 192);

        // top edge on the corner instance: 2 <= SPEED clamps to 0
        for (int i = 0; i < 96; i++) frame(n);
        chk("top_y", c_y, 0);
        chk("top_dy", c_dy, 1);
        chk("top_x", c_x, 200);
        chk("top_bc", c_bc, 2);
        frame(n);
        chk("top_next_y", c_y, 2);
        chk("d_x", sq_x, 586);
        chk("d_y", sq_y, 286);

        // steering
        btn_r = 1'b1;
        frame(n);
        chk("btn_r_x", sq_x, STEER ? 588 : 584);
        chk("btn_r_dx", dir_x, STEER ? 1 : 0);
        btn_l = 1'b1;
        frame(n);
        chk("btn_lr_x", sq_x, STEER ? 590 : 582);
        chk("btn_lr_dx", dir_x, STEER ? 1 : 0);
        btn_l = 1'b0;
        btn_r = 1'b0;
        btn_d = 1'b1;
        frame(n);
        chk("btn_d_y", sq_y, STEER ? 284 : 280);
        chk("btn_d_dy", dir_y, STEER ? 1 : 0);
        btn_d = 1'b0;
        btn_l = 1'b1;
        frame(n);
        chk("btn_l_x", sq_x, STEER ? 590 : 578);
        chk("btn_l_dx", dir_x, 0);
        btn_l = 1'b0;

        // reset released while vsync is high
        @(negedge clk);
        vsync = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (frame_tick === 1'b1) n++;
        end
        chk("vs_hi_ticks", n, 0);
        chk("vs_hi_x", sq_x, 390);
        chk("vs_hi_dx", dir_x, 1);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        frame(n);
        chk("vs_re_ticks", n, 1);
        chk("vs_re_x", sq_x, 392);
        chk("vs_re_y", sq_y, 292);

        // reset during S_UPDATE
        vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_x", sq_x, 390);
        chk("mid_rst_y", sq_y, 290);
        chk("mid_rst_bc", bounce_cnt, 0);
        chk("mid_rst_cx", c_x, 778);
        vsync = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
